// File: rtl/bean_ctrl_if.sv
// rtl/bean_ctrl_if.sv - eat request/acknowledge handshake between game logic and bean_ctrl
interface bean_ctrl_if;
  logic       eat_req;
  logic [9:0] eat_x;
  logic [8:0] eat_y;
  logic       eat_ack;
  logic       eat_hit;

  modport master (
    output eat_req, eat_x, eat_y,
    input  eat_ack, eat_hit
  );

  modport slave (
    input  eat_req, eat_x, eat_y,
    output eat_ack, eat_hit
  );
endinterface

// File: rtl/bean_ctrl.sv
// rtl/bean_ctrl.sv - bean grid owner: map load, bean count scan, eat service, score and display lookup
module bean_ctrl #(
  parameter logic [1199:0] INIT_MAP = '0,
  parameter int            BEAN_PTS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  bean_ctrl_if.slave       eat,
  input  logic [9:0]       pix_x,
  input  logic [8:0]       pix_y,
  output logic             isbean,
  output logic [1199:0]    bmap,
  output logic [10:0]      remaining,
  output logic [15:0]      score,
  output logic             level_clear,
  output logic             busy
);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [10:0] LAST_IDX = 11'd1199;

  state_t         state_q, state_d;
  logic [1199:0]  bmap_q, bmap_d;
  logic [10:0]    scan_idx_q, scan_idx_d;
  logic [10:0]    remaining_q, remaining_d;
  logic [15:0]    score_q, score_d;
  logic           ack_q, ack_d;
  logic           hit_q, hit_d;

  // Pixel to cell: 16x16 cells, 40 columns; only the visible 640x480 area maps to a cell.
  function automatic logic in_grid(input logic [9:0] x, input logic [8:0] y);
    return (x < 10'd640) && (y < 9'd480);
  endfunction

  function automatic logic [10:0] cell_idx(input logic [9:0] x, input logic [8:0] y);
    return (11'(y[8:4]) * 11'd40) + 11'(x[9:4]);
  endfunction

  logic        pix_in;
  logic [10:0] pix_idx;
  logic        eat_in;
  logic [10:0] eat_idx;
  logic        eat_bean;
  logic [16:0] score_sum;

  // Display lookup and eat-cell decode; out-of-grid coordinates are steered to index 0 and masked.
  always_comb begin
    pix_in    = in_grid(pix_x, pix_y);
    pix_idx   = pix_in ? cell_idx(pix_x, pix_y) : 11'd0;
    isbean    = pix_in && bmap_q[pix_idx];
    eat_in    = in_grid(eat.eat_x, eat.eat_y);
    eat_idx   = eat_in ? cell_idx(eat.eat_x, eat.eat_y) : 11'd0;
    eat_bean  = eat_in && bmap_q[eat_idx] && (remaining_q != 11'd0);
    score_sum = {1'b0, score_q} + 17'(BEAN_PTS);
  end

  // Next-state: scan counting, eat service in RUN, reload restores the map but keeps the score.
  always_comb begin
    state_d     = state_q;
    bmap_d      = bmap_q;
    scan_idx_d  = scan_idx_q;
    remaining_d = remaining_q;
    score_d     = score_q;
    ack_d       = 1'b0;
    hit_d       = 1'b0;

    case (state_q)
      SCAN: begin
        remaining_d = remaining_q + 11'(bmap_q[scan_idx_q]);
        scan_idx_d  = scan_idx_q + 11'd1;
        if (scan_idx_q == LAST_IDX) begin
          state_d = (remaining_d != 11'd0) ? RUN : CLEAR;
        end
      end
      RUN: begin
        // ack_q gates back-to-back service so a held request is taken every other cycle.
        if (eat.eat_req && !ack_q) begin
          ack_d = 1'b1;
          if (eat_bean) begin
            hit_d           = 1'b1;
            bmap_d[eat_idx] = 1'b0;
            remaining_d     = remaining_q - 11'd1;
            score_d         = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (remaining_q == 11'd1) begin
              state_d = CLEAR;
            end
          end
        end
      end
      CLEAR: begin
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    if (reload) begin
      state_d     = SCAN;
      bmap_d      = INIT_MAP;
      scan_idx_d  = 11'd0;
      remaining_d = 11'd0;
      ack_d       = 1'b0;
      hit_d       = 1'b0;
    end
  end

  // State register with synchronous reset that also clears the score.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      bmap_q      <= INIT_MAP;
      scan_idx_q  <= 11'd0;
      remaining_q <= 11'd0;
      score_q     <= 16'd0;
      ack_q       <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bmap_q      <= bmap_d;
      scan_idx_q  <= scan_idx_d;
      remaining_q <= remaining_d;
      score_q     <= score_d;
      ack_q       <= ack_d;
      hit_q       <= hit_d;
    end
  end

  assign eat.eat_ack = ack_q;
  assign eat.eat_hit = hit_q;
  assign bmap        = bmap_q;
  assign remaining   = remaining_q;
  assign score       = score_q;
  assign level_clear = (state_q == CLEAR);
  assign busy        = (state_q == SCAN);

endmodule

// File: tb/tb_bean_ctrl.sv
// tb/tb_bean_ctrl.sv - directed self-checking bench for bean_ctrl
module tb_bean_ctrl;

  localparam logic [1199:0] MAP_A = (1200'd1 << 41) | (1200'd1 << 42) | (1200'd1 << 1199);
  localparam logic [1199:0] MAP_F = {1200{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with the three-bean level
  logic          rst1, reload1;
  logic [9:0]    pix_x1;
  logic [8:0]    pix_y1;
  logic          isbean1, level_clear1, busy1;
  logic [1199:0] bmap1;
  logic [10:0]   rem1;
  logic [15:0]   score1;
  bean_ctrl_if   if1 ();

  bean_ctrl #(.INIT_MAP(MAP_A), .BEAN_PTS(10)) dut (
    .clk(clk), .rst(rst1), .reload(reload1), .eat(if1.slave),
    .pix_x(pix_x1), .pix_y(pix_y1), .isbean(isbean1), .bmap(bmap1),
    .remaining(rem1), .score(score1), .level_clear(level_clear1), .busy(busy1)
  );

  // DUT with a full map, used to drive the score into saturation
  logic          rst2, reload2;
  logic [9:0]    pix_x2;
  logic [8:0]    pix_y2;
  logic          isbean2, level_clear2, busy2;
  logic [1199:0] bmap2;
  logic [10:0]   rem2;
  logic [15:0]   score2;
  bean_ctrl_if   if2 ();

  bean_ctrl #(.INIT_MAP(MAP_F), .BEAN_PTS(10)) dut_full (
    .clk(clk), .rst(rst2), .reload(reload2), .eat(if2.slave),
    .pix_x(pix_x2), .pix_y(pix_y2), .isbean(isbean2), .bmap(bmap2),
    .remaining(rem2), .score(score2), .level_clear(level_clear2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  int n, acks, hits, beans;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scan1(output int cnt);
    cnt = 0;
    while (busy1 && cnt < 2000) begin
      cnt++;
      tick();
    end
  endtask

  task automatic eat1(input string tag, input logic [9:0] x, input logic [8:0] y, input logic exp_hit);
    if1.eat_req = 1'b1;
    if1.eat_x   = x;
    if1.eat_y   = y;
    tick();
    chk({tag, "_ack"}, 32'(if1.eat_ack), 32'd1);
    chk({tag, "_hit"}, 32'(if1.eat_hit), 32'(exp_hit));
    if1.eat_req = 1'b0;
    tick();
  endtask

  initial begin
    rst1 = 1'b1; reload1 = 1'b0; pix_x1 = '0; pix_y1 = '0;
    if1.eat_req = 1'b0; if1.eat_x = '0; if1.eat_y = '0;
    rst2 = 1'b1; reload2 = 1'b0; pix_x2 = '0; pix_y2 = '0;
    if2.eat_req = 1'b0; if2.eat_x = '0; if2.eat_y = '0;
    tick();
    tick();
    rst1 = 1'b0;

    chk("rst_busy", 32'(busy1), 32'd1);
    chk("rst_level_clear", 32'(level_clear1), 32'd0);
    chk("rst_remaining", 32'(rem1), 32'd0);
    chk("rst_score", 32'(score1), 32'd0);
    chk("rst_ack", 32'(if1.eat_ack), 32'd0);
    chk("rst_hit", 32'(if1.eat_hit), 32'd0);

    wait_scan1(n);
    chk("scan_cycles", 32'(n), 32'd1200);
    chk("scan_remaining", 32'(rem1), 32'd3);
    chk("scan_score", 32'(score1), 32'd0);
    chk("scan_clear", 32'(level_clear1), 32'd0);

    pix_x1 = 10'd16;  pix_y1 = 9'd16;  #1; chk("isbean_16_16", 32'(isbean1), 32'd1);
    pix_x1 = 10'd48;  pix_y1 = 9'd16;  #1; chk("isbean_48_16", 32'(isbean1), 32'd0);
    pix_x1 = 10'd639; pix_y1 = 9'd479; #1; chk("isbean_639_479", 32'(isbean1), 32'd1);
    pix_x1 = 10'd640; pix_y1 = 9'd0;   #1; chk("isbean_640_0", 32'(isbean1), 32'd0);

    eat1("eat41", 10'd20, 9'd20, 1'b1);
    chk("eat41_remaining", 32'(rem1), 32'd2);
    chk("eat41_score", 32'(score1), 32'd10);
    chk("eat41_bmap", 32'(bmap1[41]), 32'd0);
    pix_x1 = 10'd20; pix_y1 = 9'd20; #1; chk("isbean_after_eat", 32'(isbean1), 32'd0);

    eat1("reeat41", 10'd20, 9'd20, 1'b0);
    chk("reeat41_score", 32'(score1), 32'd10);

    eat1("eat_oob", 10'd700, 9'd100, 1'b0);
    chk("eat_oob_remaining", 32'(rem1), 32'd2);
    chk("eat_oob_score", 32'(score1), 32'd10);

    // A held request is acknowledged on alternate cycles only.
    acks = 0; hits = 0;
    if1.eat_req = 1'b1; if1.eat_x = 10'd20; if1.eat_y = 9'd20;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(if1.eat_ack);
      hits += int'(if1.eat_hit);
    end
    chk("held_acks", 32'(acks), 32'd2);
    chk("held_hits", 32'(hits), 32'd0);
    if1.eat_req = 1'b0;
    tick();

    // Reload wins over a same-cycle request; the held request is served after the rescan.
    reload1 = 1'b1; if1.eat_req = 1'b1; if1.eat_x = 10'd20; if1.eat_y = 9'd20;
    tick();
    reload1 = 1'b0;
    chk("reload_req_ack", 32'(if1.eat_ack), 32'd0);
    chk("reload_busy", 32'(busy1), 32'd1);
    n = 0;
    while (!if1.eat_ack && n < 3000) begin
      tick();
      n++;
    end
    chk("scan_req_latency", 32'(n), 32'd1201);
    chk("scan_req_busy", 32'(busy1), 32'd0);
    chk("scan_req_hit", 32'(if1.eat_hit), 32'd1);
    if1.eat_req = 1'b0;
    tick();
    chk("scan_req_remaining", 32'(rem1), 32'd2);
    chk("scan_req_score", 32'(score1), 32'd20);

    eat1("eat42", 10'd40, 9'd20, 1'b1);
    chk("eat42_remaining", 32'(rem1), 32'd1);
    chk("eat42_clear", 32'(level_clear1), 32'd0);

    if1.eat_req = 1'b1; if1.eat_x = 10'd632; if1.eat_y = 9'd472;
    tick();
    chk("eat1199_ack", 32'(if1.eat_ack), 32'd1);
    chk("eat1199_hit", 32'(if1.eat_hit), 32'd1);
    chk("eat1199_clear", 32'(level_clear1), 32'd1);
    chk("eat1199_remaining", 32'(rem1), 32'd0);
    chk("eat1199_score", 32'(score1), 32'd40);
    if1.eat_req = 1'b0;
    tick();

    acks = 0;
    if1.eat_req = 1'b1; if1.eat_x = 10'd20; if1.eat_y = 9'd20;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(if1.eat_ack);
    end
    if1.eat_req = 1'b0;
    chk("clear_no_ack", 32'(acks), 32'd0);
    chk("clear_stays", 32'(level_clear1), 32'd1);
    chk("clear_score", 32'(score1), 32'd40);

    reload1 = 1'b1;
    tick();
    reload1 = 1'b0;
    chk("reload_clear_low", 32'(level_clear1), 32'd0);
    wait_scan1(n);
    chk("reload_scan_cycles", 32'(n), 32'd1200);
    chk("reload_remaining", 32'(rem1), 32'd3);
    chk("reload_score_kept", 32'(score1), 32'd40);

    // Reset in the middle of a scan restarts it and clears the score.
    reload1 = 1'b1;
    tick();
    reload1 = 1'b0;
    for (int i = 0; i < 600; i++) tick();
    chk("midscan_busy", 32'(busy1), 32'd1);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("midscan_rst_score", 32'(score1), 32'd0);
    chk("midscan_rst_remaining", 32'(rem1), 32'd0);
    wait_scan1(n);
    chk("midscan_rst_cycles", 32'(n), 32'd1200);
    chk("midscan_rst_rem_final", 32'(rem1), 32'd3);

    // Full-map instance: eat whole levels until the score saturates.
    rst2 = 1'b0;
    beans = 0; acks = 0; hits = 0;
    for (int lv = 0; lv < 6; lv++) begin
      n = 0;
      while (busy2 && n < 1300) begin
        tick();
        n++;
      end
      chk("full_scan_remaining", 32'(rem2), 32'd1200);
      for (int c = 0; c < 1200; c++) begin
        if (beans < 6555) begin
          if2.eat_req = 1'b1;
          if2.eat_x   = 10'((c % 40) * 16 + 8);
          if2.eat_y   = 9'((c / 40) * 16 + 8);
          tick();
          acks += int'(if2.eat_ack);
          hits += int'(if2.eat_hit);
          if2.eat_req = 1'b0;
          tick();
          beans++;
          if (beans == 6553) chk("sat_6553", 32'(score2), 32'h0000FFFA);
          if (beans == 6554) chk("sat_6554", 32'(score2), 32'h0000FFFF);
          if (beans == 6555) chk("sat_6555", 32'(score2), 32'h0000FFFF);
        end
      end
      if (lv == 0) chk("full_lv0_score", 32'(score2), 32'd12000);
      if (beans < 6555) begin
        chk("full_level_clear", 32'(level_clear2), 32'd1);
        reload2 = 1'b1;
        tick();
        reload2 = 1'b0;
      end
    end
    chk("full_acks", 32'(acks), 32'd6555);
    chk("full_hits", 32'(hits), 32'd6555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bean_ctrl.md
Name: bean_ctrl

Overview:
Owns the 40x30 bean grid (1200 cells, 16x16-pixel cells over a 640x480 screen) and sequences every change to it. It loads the initial map, counts beans with a sequential scan, and serves eat requests from game logic through a req/ack handshake. It also keeps score and remaining count, flags level clear, and gives the VGA display path a combinational bean lookup. It sits between the game FSM (pacman movement) and the display module.

Parameters:
INIT_MAP, 1200'b0 (game build overrides with the level layout), initial bean bitmap; bit index = row*40 + col.
BEAN_PTS, 10, score increment per bean eaten.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
reload  in  1  one-cycle pulse: restore INIT_MAP and rescan (next level)
eat_req  in  1  level request to eat at (eat_x,eat_y); held until eat_ack
eat_x  in  10  pacman centre pixel x
eat_y  in  9  pacman centre pixel y
eat_ack  out  1  one-cycle acknowledge of eat_req
eat_hit  out  1  valid with eat_ack: a bean was removed
pix_x  in  10  display pixel x
pix_y  in  9  display pixel y
isbean  out  1  combinational: cell under (pix_x,pix_y) holds a bean
bmap  out  1200  current bean bitmap
remaining  out  11  beans left (valid when busy=0)
score  out  16  accumulated score
level_clear  out  1  high while in CLEAR state
busy  out  1  high during SCAN

Behaviour:
- Cell mapping: col = x>>4, row = y>>4, idx = row*40+col; in range only if x<640 and y<480.
- isbean = in range and bmap[idx], else 0; purely combinational, no latency.
- States: SCAN, RUN, CLEAR.
- rst (any state, including mid-scan): bmap<=INIT_MAP, scan_idx<=0, remaining<=0, score<=0, eat_ack<=0, eat_hit<=0, state<=SCAN. The reset values of level_clear and busy follow from state: level_clear=0 and busy=1.
- reload (not rst): same as rst except score is kept. reload has priority over a same-cycle eat_req, which gets no ack that cycle.
- SCAN: each cycle remaining += bmap[scan_idx] and scan_idx++, for idx 0..1199. This takes exactly 1200 cycles. On the cycle after idx 1199, go to RUN if remaining!=0, else CLEAR. busy=1 throughout.
- eat_req is not acked in SCAN or CLEAR; the requester keeps holding it.
- RUN handling of eat_req=1 while eat_ack=0 (registered, 1-cycle latency):
  - next cycle eat_ack=1;
  - eat_hit=1 iff the cell is in range and bmap[idx]=1;
  - on a hit, in the same edge: bmap[idx]<=0, remaining<=remaining-1, score<=min(score+BEAN_PTS, 16'hFFFF) (saturating).
- eat_ack is never high two cycles in a row. A held req is re-serviced every other cycle; the second service of the same cell gives hit=0.
- On a hit that drops remaining 1->0: state<=CLEAR on that same edge, and level_clear rises together with that eat_ack.
- CLEAR: bmap and score are static; leave only via reload or rst.
- eat_hit=0 whenever eat_ack=0.
- remaining never underflows; a hit is only possible while remaining>0.

Test Plan:
- INIT_MAP with bits 41,42,1199 set; release rst → busy=1 for exactly 1200 cycles, then busy=0, remaining=3, score=0, state RUN.
- isbean checks: pix (16,16) → isbean=1; pix (48,16) → 0; pix (639,479) → 1 (idx 1199); pix (640,0) → 0.
- eat_req at (20,20) → eat_ack one cycle later with eat_hit=1; then remaining=2, score=10, bmap[41]=0. Re-request same cell → ack, hit=0, score still 10.
- Request at (700,100) → ack, hit=0, no state change. eat_req asserted during SCAN → no ack until busy falls, then acked.
- Eat cells 42 then 1199 → last ack coincides with level_clear=1 and remaining=0. Further req → no ack. reload → 1200-cycle rescan, remaining=3, score=30 retained.
- Force score=16'hFFF8 and eat a bean → score=16'hFFFF. Assert rst at scan idx 600 → scan restarts, score=0. Same-cycle reload+eat_req → no ack, rescan begins.
